// File: rtl/bus_timer_slave_pkg.sv
// Shared definitions for the bus timer: register offsets, CTRL bit layout,
// MODE encodings and FSM state encodings.
package bus_timer_slave_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_BITS     = 4;

    localparam logic [1:0] MODE_ONE_SHOT = 2'b00;
    localparam logic [1:0] MODE_PERIODIC = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_e;

    // Any MODE other than periodic, including the unused codes, behaves as one-shot.
    function automatic logic is_periodic(input logic [CTRL_BITS-1:0] ctrl);
        return (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_PERIODIC) &&
               (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] != MODE_ONE_SHOT);
    endfunction

endpackage

// File: rtl/bus_timer_slave_prescaler.sv
// Count-tick generator: one tick every PRESCALE clocks while the timer is counting.
// Used by bus_timer_slave only when TIMER_PRESCALE_EN is defined.
module bus_timer_slave_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (!i_reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            if (o_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/bus_timer_slave.sv
// Memory-mapped down-counting timer slave (CTRL / PRESET / COUNT), one-shot or periodic irq.
// Optional count prescaler enabled by defining TIMER_PRESCALE_EN.
import bus_timer_slave_pkg::*;

module bus_timer_slave #(
    parameter int WIDTH    = 32,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq
);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("PRESCALE must be >= 1");
    end

    logic [CTRL_BITS-1:0] r_ctrl;
    logic [WIDTH-1:0]     r_preset;
    logic [WIDTH-1:0]     r_count;
    logic                 r_irq_flag;
    timer_state_e         r_state;

    timer_state_e         w_state_next;
    logic [WIDTH-1:0]     w_count_next;
    logic                 w_set_flag;
    logic                 w_clr_flag;
    logic                 w_clr_en;
    logic                 w_ctrl_wr;
    logic                 w_preset_wr;
    logic                 w_tick;

    assign w_ctrl_wr   = sel && we && (addr == ADDR_CTRL);
    assign w_preset_wr = sel && we && (addr == ADDR_PRESET);

`ifdef TIMER_PRESCALE_EN
    logic w_ps_clear;
    logic w_ps_run;

    assign w_ps_clear = (r_state == ST_LOAD);
    assign w_ps_run   = (r_state == ST_CNT);

    bus_timer_slave_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .i_clk   (clk),
        .i_reset (reset),
        .i_clear (w_ps_clear),
        .i_run   (w_ps_run),
        .o_tick  (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Expiry drives COUNT to 0 directly, so PRESET=0 and PRESET=1 time out alike.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_set_flag   = 1'b0;
        w_clr_flag   = 1'b0;
        w_clr_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_ctrl[CTRL_EN_BIT]) begin
                    w_state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_count_next = r_preset;
                w_state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!r_ctrl[CTRL_EN_BIT]) begin
                    w_state_next = ST_IDLE;
                end else if (w_tick) begin
                    if (r_count > WIDTH'(1)) begin
                        w_count_next = r_count - WIDTH'(1);
                    end else begin
                        w_count_next = '0;
                        w_set_flag   = 1'b1;
                        w_state_next = ST_INT;
                    end
                end
            end
            ST_INT: begin
                if (is_periodic(r_ctrl)) begin
                    w_clr_flag   = 1'b1;
                    w_state_next = ST_LOAD;
                end else begin
                    w_clr_en     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A bus write to CTRL overrides the one-shot EN clear landing on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ctrl <= '0;
        end else if (w_ctrl_wr) begin
            r_ctrl <= wdata[CTRL_BITS-1:0];
        end else if (w_clr_en) begin
            r_ctrl[CTRL_EN_BIT] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_preset <= '0;
        end else if (w_preset_wr) begin
            r_preset <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_irq_flag <= 1'b0;
        end else if (w_ctrl_wr || w_clr_flag) begin
            r_irq_flag <= 1'b0;
        end else if (w_set_flag) begin
            r_irq_flag <= 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_CTRL:   rdata[CTRL_BITS-1:0] = r_ctrl;
            ADDR_PRESET: rdata = r_preset;
            ADDR_COUNT:  rdata = r_count;
            ADDR_RSVD:   rdata = '0;
            default:     rdata = '0;
        endcase
    end

    assign irq = r_ctrl[CTRL_IM_BIT] & r_irq_flag;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Self-checking bench for bus_timer_slave: register access, one-shot, periodic,
// pause/reload, masking, PRESET update, write/expiry race and reset behaviour.
module tb_bus_timer_slave;

    localparam int W = 32;
`ifdef TIMER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         sel   = 1'b0;
    logic         we    = 1'b0;
    logic [1:0]   addr  = 2'd0;
    logic [W-1:0] wdata = '0;
    logic [W-1:0] rdata;
    logic         irq;

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] exp_q[$];
    int           edge_q[$];

    bus_timer_slave #(
        .WIDTH    (W),
        .PRESCALE (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        step();
        sel   = 1'b0;
        we    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [W-1:0] d);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        d = rdata;
    endtask

    task automatic apply_reset();
        sel   = 1'b0;
        we    = 1'b0;
        reset = 1'b0;
        steps(2);
        reset = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [W-1:0] v;
        reset = 1'b0;
        sel   = 1'b1;
        we    = 1'b1;
        addr  = 2'd1;
        wdata = $urandom;
        step();
        sel = 1'b0;
        we  = 1'b0;
        step();
        reset = 1'b1;
        step();
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), v);
            n_total++;
            if (v !== '0) $display("FAIL reset_rdata[%0d] got=%0h exp=0", a, v);
            else n_pass++;
        end
        n_total++;
        if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq);
        else n_pass++;
    endtask

    task automatic test_registers();
        logic [W-1:0] v;
        logic [W-1:0] d;
        apply_reset();
        d = $urandom;
        bus_write(2'd1, d);
        bus_read(2'd1, v);
        n_total++;
        if (v !== d) $display("FAIL reg_preset got=%0h exp=%0h", v, d);
        else n_pass++;
        bus_write(2'd0, 32'hFFFF_FFF6);
        bus_read(2'd0, v);
        n_total++;
        if (v !== 32'h6) $display("FAIL reg_ctrl_mask got=%0h exp=6", v);
        else n_pass++;
        bus_write(2'd2, $urandom | 32'h1);
        bus_read(2'd2, v);
        n_total++;
        if (v !== '0) $display("FAIL reg_count_ro got=%0h exp=0", v);
        else n_pass++;
        bus_write(2'd3, $urandom | 32'h1);
        bus_read(2'd3, v);
        n_total++;
        if (v !== '0) $display("FAIL reg_reserved got=%0h exp=0", v);
        else n_pass++;
        bus_write(2'd0, '0);
    endtask

    task automatic test_one_shot();
        logic [W-1:0] v;
        logic [W-1:0] e;
        int p;
        int ex;
        apply_reset();
        p  = 5;
        ex = 2 + p * PS;
        bus_write(2'd1, W'(p));
        for (int k = 1; k <= ex + 1; k++) begin
            if (k < 2)       exp_q.push_back('0);
            else if (k < ex) exp_q.push_back(W'(p - (k - 2) / PS));
            else             exp_q.push_back('0);
            exp_q.push_back((k >= ex) ? W'(1) : W'(0));
        end
        bus_write(2'd0, 32'h9);
        for (int k = 1; k <= ex + 1; k++) begin
            step();
            bus_read(2'd2, v);
            e = exp_q.pop_front();
            n_total++;
            if (v !== e) $display("FAIL oneshot_count@%0d got=%0h exp=%0h", k, v, e);
            else n_pass++;
            e = exp_q.pop_front();
            n_total++;
            if (irq !== e[0]) $display("FAIL oneshot_irq@%0d got=%b exp=%b", k, irq, e[0]);
            else n_pass++;
        end
        bus_read(2'd0, v);
        n_total++;
        if (v !== 32'h8) $display("FAIL oneshot_en_clear got=%0h exp=8", v);
        else n_pass++;
        steps(3);
        n_total++;
        if (irq !== 1'b1) $display("FAIL oneshot_irq_held got=%b exp=1", irq);
        else n_pass++;
        bus_read(2'd2, v);
        n_total++;
        if (v !== '0) $display("FAIL oneshot_no_reload got=%0h exp=0", v);
        else n_pass++;
        bus_write(2'd0, 32'h8);
        n_total++;
        if (irq !== 1'b0) $display("FAIL oneshot_irq_ctrl_clear got=%b exp=0", irq);
        else n_pass++;
    endtask

    task automatic test_periodic();
        logic [W-1:0] e;
        int p;
        int period;
        int last;
        int pulses;
        apply_reset();
        p      = 3;
        period = 2 + p * PS;
        last   = period + 3 * period + 1;
        pulses = 0;
        bus_write(2'd1, W'(p));
        for (int k = 1; k <= last; k++)
            exp_q.push_back(((k >= period) && ((k - period) % period == 0)) ? W'(1) : W'(0));
        bus_write(2'd0, 32'hB);
        for (int k = 1; k <= last; k++) begin
            step();
            e = exp_q.pop_front();
            if (irq === 1'b1) pulses++;
            n_total++;
            if (irq !== e[0]) $display("FAIL periodic_irq@%0d got=%b exp=%b", k, irq, e[0]);
            else n_pass++;
        end
        n_total++;
        if (pulses !== 4) $display("FAIL periodic_pulse_count got=%0d exp=4", pulses);
        else n_pass++;
    endtask

    task automatic test_pause();
        logic [W-1:0] v;
        int p;
        int t;
        apply_reset();
        p = 6;
        t = 2 + (p - 3) * PS;
        bus_write(2'd1, W'(p));
        bus_write(2'd0, 32'h9);
        steps(t - 1);
        bus_write(2'd0, 32'h8);
        bus_read(2'd2, v);
        n_total++;
        if (v !== W'(3)) $display("FAIL pause_count_at_write got=%0h exp=3", v);
        else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            step();
            bus_read(2'd2, v);
            n_total++;
            if (v !== W'(3) || irq !== 1'b0)
                $display("FAIL pause_hold@%0d got=%0h/%b exp=3/0", i, v, irq);
            else n_pass++;
        end
        bus_write(2'd0, 32'h9);
        step();
        bus_read(2'd2, v);
        n_total++;
        if (v !== W'(3)) $display("FAIL pause_load_edge got=%0h exp=3", v);
        else n_pass++;
        step();
        bus_read(2'd2, v);
        n_total++;
        if (v !== W'(p)) $display("FAIL pause_reload got=%0h exp=%0h", v, p);
        else n_pass++;
    endtask

    task automatic test_mask_preset();
        logic [W-1:0] v;
        logic [W-1:0] e;
        int period1;
        int e2;
        int e3;
        int e4;
        int wr;
        int k;
        apply_reset();
        period1 = 2 + 3 * PS;
        e2 = 2 * period1;
        e3 = 3 * period1;
        e4 = e3 + 2 + 2 * PS;
        wr = e2 + 3;
        edge_q.push_back(e2 + 2);      exp_q.push_back(W'(3));
        edge_q.push_back(e3);          exp_q.push_back(W'(0));
        edge_q.push_back(e3 + 1);      exp_q.push_back(W'(0));
        edge_q.push_back(e3 + 2);      exp_q.push_back(W'(2));
        edge_q.push_back(e3 + 2 + PS); exp_q.push_back(W'(1));
        edge_q.push_back(e4);          exp_q.push_back(W'(0));
        edge_q.push_back(e4 + 2);      exp_q.push_back(W'(2));
        bus_write(2'd1, W'(3));
        bus_write(2'd0, 32'h3);
        for (k = 1; k <= e4 + 2; k++) begin
            if (k == wr) bus_write(2'd1, W'(2));
            else step();
            n_total++;
            if (irq !== 1'b0) $display("FAIL masked_irq@%0d got=%b exp=0", k, irq);
            else n_pass++;
            if (edge_q.size() > 0 && edge_q[0] == k) begin
                void'(edge_q.pop_front());
                e = exp_q.pop_front();
                bus_read(2'd2, v);
                n_total++;
                if (v !== e) $display("FAIL preset_update_count@%0d got=%0h exp=%0h", k, v, e);
                else n_pass++;
            end
        end
        n_total++;
        if (edge_q.size() !== 0) $display("FAIL preset_update_unchecked got=%0d exp=0", edge_q.size());
        else n_pass++;
    endtask

    task automatic test_preset_zero();
        logic [W-1:0] v;
        int ex;
        apply_reset();
        ex = 2 + PS;
        bus_write(2'd1, '0);
        bus_write(2'd0, 32'h9);
        steps(ex - 1);
        n_total++;
        if (irq !== 1'b0) $display("FAIL preset0_early got=%b exp=0", irq);
        else n_pass++;
        step();
        bus_read(2'd2, v);
        n_total++;
        if (irq !== 1'b1 || v !== '0) $display("FAIL preset0_expire got=%b/%0h exp=1/0", irq, v);
        else n_pass++;
    endtask

    task automatic test_int_write_race();
        logic [W-1:0] v;
        int ex;
        apply_reset();
        ex = 2 + PS;
        bus_write(2'd1, W'(1));
        bus_write(2'd0, 32'h9);
        steps(ex);
        n_total++;
        if (irq !== 1'b1) $display("FAIL race_expire got=%b exp=1", irq);
        else n_pass++;
        bus_write(2'd0, 32'h9);
        bus_read(2'd0, v);
        n_total++;
        if (v !== 32'h9 || irq !== 1'b0) $display("FAIL race_bus_wins got=%0h/%b exp=9/0", v, irq);
        else n_pass++;
        steps(1 + PS);
        n_total++;
        if (irq !== 1'b0) $display("FAIL race_rerun_early got=%b exp=0", irq);
        else n_pass++;
        step();
        n_total++;
        if (irq !== 1'b1) $display("FAIL race_rerun_expire got=%b exp=1", irq);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v;
        int ex;
        apply_reset();
        ex = 2 + 2 * PS;
        bus_write(2'd1, W'(2));
        bus_write(2'd0, 32'h9);
        steps(ex - 1);
        n_total++;
        if (irq !== 1'b0) $display("FAIL rst_expire_early got=%b exp=0", irq);
        else n_pass++;
        step();
        n_total++;
        if (irq !== 1'b1) $display("FAIL rst_expire_edge got=%b exp=1", irq);
        else n_pass++;
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_total++;
        if (irq !== 1'b0) $display("FAIL rst_pending_irq got=%b exp=0", irq);
        else n_pass++;
        bus_write(2'd1, W'(7));
        bus_write(2'd0, 32'h9);
        steps(3);
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), v);
            n_total++;
            if (v !== '0) $display("FAIL rst_mid_rdata[%0d] got=%0h exp=0", a, v);
            else n_pass++;
        end
        steps(3);
        bus_read(2'd2, v);
        n_total++;
        if (v !== '0 || irq !== 1'b0) $display("FAIL rst_mid_idle got=%0h/%b exp=0/0", v, irq);
        else n_pass++;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_registers();
        test_one_shot();
        test_periodic();
        test_pause();
        test_mask_preset();
        test_preset_zero();
        test_int_write_race();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
